// File: rtl/text_buffer_writer.sv
// ---------------------------------------------------------------------------
// text_buffer_writer
//
// Write-port driver for a 2D character RAM of ROWS x COLS cells, each
// DATA_WIDTH bits wide. A stream of ASCII bytes arrives over a valid/ready
// handshake. Each byte becomes at most one single-cycle RAM write, and the
// block keeps a text cursor. A clear request sweeps a space (0x20) into every
// cell.
//
// Handshake: a byte is taken on every rising edge where in_valid && in_ready.
// in_ready is combinational and depends only on the FSM state and on clear.
// The producer may hold in_valid high for any number of cycles. A byte that
// is not taken must be presented again.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_valid    in_data carries a byte
//   in_data     ASCII byte
//   in_ready    byte will be taken this edge: (state == IDLE) && !clear
//   clear       request a full-buffer clear (only looked at in IDLE)
//   we          RAM write enable (registered, one cycle per write)
//   w_row       RAM write row (registered)
//   w_col       RAM write column (registered)
//   din         RAM write data (registered, zero-extended byte)
//   cur_row     cursor row
//   cur_col     cursor column
//   busy        clear sweep in progress
//   dbg_state_o FSM state (0 = IDLE, 1 = CLEAR)
// ---------------------------------------------------------------------------
module text_buffer_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 32,
    localparam int RW        = $clog2(ROWS),
    localparam int CW        = $clog2(COLS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  clear,
    output logic                  we,
    output logic [RW-1:0]         w_row,
    output logic [CW-1:0]         w_col,
    output logic [DATA_WIDTH-1:0] din,
    output logic [RW-1:0]         cur_row,
    output logic [CW-1:0]         cur_col,
    output logic                  busy,
    output logic                  dbg_state_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [7:0]    CH_BS    = 8'h08;
    localparam logic [7:0]    CH_LF    = 8'h0A;
    localparam logic [7:0]    CH_CR    = 8'h0D;
    localparam logic [7:0]    CH_SPACE = 8'h20;
    localparam logic [7:0]    CH_TILDE = 8'h7E;

    // Wrap points are compared explicitly, so that row and column counts
    // that are not a power of two still wrap correctly.
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_t                  state_q, state_d;
    logic [RW-1:0]           cur_row_q, cur_row_d;
    logic [CW-1:0]           cur_col_q, cur_col_d;
    logic [RW-1:0]           sw_row_q, sw_row_d;   // clear-sweep position
    logic [CW-1:0]           sw_col_q, sw_col_d;
    logic                    we_q, we_d;
    logic [RW-1:0]           w_row_q, w_row_d;
    logic [CW-1:0]           w_col_q, w_col_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;

    logic                    accept;
    logic                    printable;
    logic                    col_at_last;
    logic                    row_at_last;

    assign in_ready    = (state_q == ST_IDLE) && !clear;
    assign accept      = in_valid && in_ready;
    assign printable   = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);
    assign col_at_last = (cur_col_q == COL_LAST);
    assign row_at_last = (cur_row_q == ROW_LAST);

    // ------------------------------------------------------------------
    // Next-state, cursor and write-port logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        cur_col_d = cur_col_q;
        sw_row_d  = sw_row_q;
        sw_col_d  = sw_col_q;
        we_d      = 1'b0;
        w_row_d   = w_row_q;
        w_col_d   = w_col_q;
        din_d     = din_q;

        unique case (state_q)
            ST_IDLE: begin
                if (clear) begin
                    // Clear wins over a simultaneous byte. in_ready is
                    // already low, so the byte stays with the producer.
                    state_d  = ST_CLEAR;
                    sw_row_d = '0;
                    sw_col_d = '0;
                end else if (accept) begin
                    if (printable) begin
                        we_d    = 1'b1;
                        w_row_d = cur_row_q;
                        w_col_d = cur_col_q;
                        din_d   = DATA_WIDTH'(in_data);
                        if (col_at_last) begin
                            cur_col_d = '0;
                            cur_row_d = row_at_last ? '0 : cur_row_q + RW'(1);
                        end else begin
                            cur_col_d = cur_col_q + CW'(1);
                        end
                    end else if (in_data == CH_LF) begin
                        cur_col_d = '0;
                        cur_row_d = row_at_last ? '0 : cur_row_q + RW'(1);
                    end else if (in_data == CH_CR) begin
                        cur_col_d = '0;
                    end else if (in_data == CH_BS) begin
                        // Step back one cell and blank it. At the origin the
                        // byte is taken but nothing happens.
                        if (cur_col_q != '0) begin
                            cur_col_d = cur_col_q - CW'(1);
                            we_d      = 1'b1;
                            w_row_d   = cur_row_q;
                            w_col_d   = cur_col_q - CW'(1);
                            din_d     = DATA_WIDTH'(CH_SPACE);
                        end else if (cur_row_q != '0) begin
                            cur_row_d = cur_row_q - RW'(1);
                            cur_col_d = COL_LAST;
                            we_d      = 1'b1;
                            w_row_d   = cur_row_q - RW'(1);
                            w_col_d   = COL_LAST;
                            din_d     = DATA_WIDTH'(CH_SPACE);
                        end
                    end
                    // Any other byte is taken and dropped.
                end
            end

            ST_CLEAR: begin
                // One cell per cycle in row-major order. clear is not looked
                // at here, so a repeated request cannot restart the sweep.
                we_d    = 1'b1;
                w_row_d = sw_row_q;
                w_col_d = sw_col_q;
                din_d   = DATA_WIDTH'(CH_SPACE);
                if (sw_col_q == COL_LAST) begin
                    sw_col_d = '0;
                    if (sw_row_q == ROW_LAST) begin
                        state_d   = ST_IDLE;
                        sw_row_d  = '0;
                        cur_row_d = '0;
                        cur_col_d = '0;
                    end else begin
                        sw_row_d = sw_row_q + RW'(1);
                    end
                end else begin
                    sw_col_d = sw_col_q + CW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cur_row_q <= '0;
            cur_col_q <= '0;
            sw_row_q  <= '0;
            sw_col_q  <= '0;
            we_q      <= 1'b0;
            w_row_q   <= '0;
            w_col_q   <= '0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            cur_row_q <= cur_row_d;
            cur_col_q <= cur_col_d;
            sw_row_q  <= sw_row_d;
            sw_col_q  <= sw_col_d;
            we_q      <= we_d;
            w_row_q   <= w_row_d;
            w_col_q   <= w_col_d;
            din_q     <= din_d;
        end
    end

    assign we          = we_q;
    assign w_row       = w_row_q;
    assign w_col       = w_col_q;
    assign din         = din_q;
    assign cur_row     = cur_row_q;
    assign cur_col     = cur_col_q;
    assign busy        = (state_q == ST_CLEAR);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
module tb_text_buffer_writer;

    localparam int DW    = 8;
    localparam int ROWS  = 4;
    localparam int COLS  = 32;
    localparam int CELLS = ROWS * COLS;
    localparam int RW    = $clog2(ROWS);
    localparam int CW    = $clog2(COLS);
    localparam int QW    = RW + CW + DW;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          clear;
    logic          we;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic [DW-1:0] din;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] cur_col;
    logic          busy;
    logic          dbg_state;

    text_buffer_writer #(
        .DATA_WIDTH(DW),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .clear      (clear),
        .we         (we),
        .w_row      (w_row),
        .w_col      (w_col),
        .din        (din),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .busy       (busy),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int tests;
    int fails;

    // Reference model: cursor as a linear cell index plus the expected RAM.
    int exp_row;
    int exp_col;
    int exp_ram[CELLS];

    // Shadow RAM built from the writes the DUT actually issues.
    int shadow[CELLS];

    // Expected clear-sweep writes, packed {row, col, data}.
    logic [QW-1:0] exp_q[$];

    always @(negedge clk) begin
        if (we === 1'b1) shadow[int'(w_row) * COLS + int'(w_col)] = int'(din);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies one byte to the model: expected write and new cursor.
    task automatic model_step(input logic [7:0] b, output logic ew, output int er,
                              output int ec, output int ed);
        int idx;
        idx = exp_row * COLS + exp_col;
        ew = 1'b0; er = 0; ec = 0; ed = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            ew = 1'b1; er = exp_row; ec = exp_col; ed = int'(b);
            exp_ram[idx] = int'(b);
            idx = (idx + 1) % CELLS;
            exp_row = idx / COLS;
            exp_col = idx % COLS;
        end else if (b == 8'h0A) begin
            exp_row = (exp_row + 1) % ROWS;
            exp_col = 0;
        end else if (b == 8'h0D) begin
            exp_col = 0;
        end else if (b == 8'h08) begin
            if (idx > 0) begin
                idx = idx - 1;
                ew = 1'b1; er = idx / COLS; ec = idx % COLS; ed = 32'h20;
                exp_ram[idx] = 32'h20;
                exp_row = er;
                exp_col = ec;
            end
        end
    endtask

    // ---------------- driver tasks (called #1 after a rising edge) ----------------
    task automatic drive_byte(input logic [7:0] b);
        logic ew;
        int   er, ec, ed;
        check("in_ready_idle", in_ready, 1);
        model_step(b, ew, er, ec, ed);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("we", we, ew);
        if (ew) begin
            check("w_row", w_row, er);
            check("w_col", w_col, ec);
            check("din", din, ed);
        end
        check("cur_row", cur_row, exp_row);
        check("cur_col", cur_col, exp_col);
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("we_idle", we, 0);
    endtask

    task automatic compare_ram(input string name);
        for (int k = 0; k < CELLS; k++) check(name, shadow[k], exp_ram[k]);
    endtask

    // Clear sweep. abort_at >= 0: reset once that many writes were seen.
    // reclear_at > 0: pulse clear again at that busy cycle.
    task automatic run_clear(input int abort_at, input int reclear_at);
        int  busy_cycles;
        int  writes;
        bit  done;
        logic [QW-1:0] e;
        busy_cycles = 0;
        writes      = 0;
        done        = 0;
        exp_q.delete();
        for (int k = 0; k < CELLS; k++)
            exp_q.push_back({RW'(k / COLS), CW'(k % COLS), DW'(8'h20)});
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h41;
        #1;
        check("in_ready_during_clear_req", in_ready, 0);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("busy_after_clear", busy, 1);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (busy) begin
                busy_cycles++;
                check("in_ready_busy", in_ready, 0);
            end
            if (we) begin
                writes++;
                if (exp_q.size() == 0) begin
                    check("clear_extra_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("clear_write", {w_row, w_col, din}, e);
                end
            end
            if (abort_at >= 0 && writes == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                check("abort_we", we, 0);
                check("abort_busy", busy, 0);
                check("abort_cur_row", cur_row, 0);
                check("abort_cur_col", cur_col, 0);
                check("abort_in_ready", in_ready, 1);
                for (int k = 0; k < abort_at; k++) exp_ram[k] = 32'h20;
                done = 1;
            end else if (!busy && !we && busy_cycles > 0) begin
                done = 1;
            end else begin
                if (reclear_at > 0 && busy_cycles == reclear_at) clear = 1'b1;
                @(posedge clk);
                #1;
                clear = 1'b0;
            end
        end
        check("clear_finished", done, 1);
        if (abort_at < 0) begin
            check("clear_busy_cycles", busy_cycles, CELLS);
            check("clear_writes", writes, CELLS);
            check("clear_queue_empty", exp_q.size(), 0);
            check("clear_cur_row", cur_row, 0);
            check("clear_cur_col", cur_col, 0);
            check("clear_in_ready", in_ready, 1);
            for (int k = 0; k < CELLS; k++) exp_ram[k] = 32'h20;
        end
        exp_row = 0;
        exp_col = 0;
        exp_q.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic       we;
        int         row;
        int         col;
        int         din;
        int         crow;
        int         ccol;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic ew;
        int   er, ec, ed;
        logic [7:0] b;

        tests = 0; fails = 0;
        exp_row = 0; exp_col = 0;
        for (int k = 0; k < CELLS; k++) begin exp_ram[k] = 0; shadow[k] = 0; end

        vecs[0]  = '{8'h48, 1'b1, 0, 0,  32'h48, 0, 1};
        vecs[1]  = '{8'h69, 1'b1, 0, 1,  32'h69, 0, 2};
        vecs[2]  = '{8'h0D, 1'b0, 0, 0,  0,      0, 0};
        vecs[3]  = '{8'h08, 1'b0, 0, 0,  0,      0, 0};
        vecs[4]  = '{8'h0A, 1'b0, 0, 0,  0,      1, 0};
        vecs[5]  = '{8'h08, 1'b1, 0, 31, 32'h20, 0, 31};
        vecs[6]  = '{8'h42, 1'b1, 0, 31, 32'h42, 1, 0};
        vecs[7]  = '{8'h0A, 1'b0, 0, 0,  0,      2, 0};
        vecs[8]  = '{8'h07, 1'b0, 0, 0,  0,      2, 0};
        vecs[9]  = '{8'h7F, 1'b0, 0, 0,  0,      2, 0};
        vecs[10] = '{8'h7E, 1'b1, 2, 0,  32'h7E, 2, 1};
        vecs[11] = '{8'h20, 1'b1, 2, 1,  32'h20, 2, 2};
        vecs[12] = '{8'h0A, 1'b0, 0, 0,  0,      3, 0};
        vecs[13] = '{8'h0A, 1'b0, 0, 0,  0,      0, 0};
        vecs[14] = '{8'h1F, 1'b0, 0, 0,  0,      0, 0};
        vecs[15] = '{8'h80, 1'b0, 0, 0,  0,      0, 0};

        // ---------------- reset ----------------
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_we", we, 0);
        check("rst_w_row", w_row, 0);
        check("rst_w_col", w_col, 0);
        check("rst_din", din, 0);
        check("rst_cur_row", cur_row, 0);
        check("rst_cur_col", cur_col, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);

        // ---------------- table, back-to-back bytes ----------------
        for (int i = 0; i < 16; i++) begin
            check("tbl_in_ready", in_ready, 1);
            model_step(vecs[i].data, ew, er, ec, ed);
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check("tbl_we", we, vecs[i].we);
            if (vecs[i].we) begin
                check("tbl_w_row", w_row, vecs[i].row);
                check("tbl_w_col", w_col, vecs[i].col);
                check("tbl_din", din, vecs[i].din);
            end
            check("tbl_cur_row", cur_row, vecs[i].crow);
            check("tbl_cur_col", cur_col, vecs[i].ccol);
        end
        in_valid = 1'b0;

        // ---------------- column wrap, LF wrap ----------------
        for (int i = 0; i < COLS; i++) drive_byte(8'h41);
        check("wrap_cur_row", cur_row, 1);
        check("wrap_cur_col", cur_col, 0);
        for (int i = 0; i < 3; i++) drive_byte(8'h0A);
        check("lf_wrap_row", cur_row, 0);

        // ---------------- control filtering at (2,5) ----------------
        drive_byte(8'h0A); drive_byte(8'h0A);
        for (int i = 0; i < 5; i++) drive_byte(8'h42);
        drive_byte(8'h07); drive_byte(8'h7F); drive_byte(8'h0D);
        check("filter_cur_row", cur_row, 2);
        check("filter_cur_col", cur_col, 0);

        // ---------------- last cell wraps to origin ----------------
        drive_byte(8'h0A);
        for (int i = 0; i < COLS; i++) drive_byte(8'h43);
        check("last_cell_wrap_row", cur_row, 0);
        check("last_cell_wrap_col", cur_col, 0);

        // ---------------- randomized ----------------
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: b = 8'($urandom_range(8'h20, 8'h7E));
                6: b = 8'h0A;
                7: b = 8'h0D;
                8: b = 8'h08;
                default: b = 8'($urandom_range(0, 255));
            endcase
            drive_byte(b);
        end
        idle_cycle();
        compare_ram("ram_after_random");

        // ---------------- clear, with a mid-sweep clear pulse ----------------
        run_clear(-1, 60);
        idle_cycle();
        compare_ram("ram_after_clear");
        drive_byte(8'h48);
        check("post_clear_write_row", w_row, 0);

        // ---------------- fill, then reset during clear ----------------
        for (int i = 1; i < CELLS; i++) drive_byte(8'(8'h21 + (i % 90)));
        drive_byte(8'h5A);
        run_clear(40, 0);
        idle_cycle();
        compare_ram("ram_after_abort");
        drive_byte(8'h48);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Upstream write-port driver for the 2D dual-port character RAM (ROWS x COLS cells of DATA_WIDTH bits).
- Accepts a byte stream (keyboard/UART decoded ASCII) over a valid/ready handshake and maintains a text cursor.
- Converts printable characters and control codes into single-cycle RAM writes (we/w_row/w_col/din).
- Provides a full-buffer clear sweep that fills every cell with space.

Parameters:
- DATA_WIDTH, 8, width of a character cell; must be >= 8.
- ROWS, 4, number of text rows; must be >= 2.
- COLS, 32, number of text columns; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a byte to consume.
- in_data  input  8  ASCII byte.
- in_ready  output  1  combinational: (state==IDLE) && !clear.
- clear  input  1  request a full-buffer clear; sampled only in IDLE.
- we  output  1  RAM write enable, registered.
- w_row  output  $clog2(ROWS)  RAM write row, registered.
- w_col  output  $clog2(COLS)  RAM write column, registered.
- din  output  DATA_WIDTH  RAM write data, registered, zero-extended from 8 bits.
- cur_row  output  $clog2(ROWS)  current cursor row.
- cur_col  output  $clog2(COLS)  current cursor column.
- busy  output  1  high while in CLEAR.

Behaviour:
- Reset:
  - All of the following take effect on the same edge: state=IDLE, we=0, w_row=0, w_col=0, din=0, cur_row=0, cur_col=0, busy=0.
  - rst during CLEAR aborts the sweep; we is 0 from the next cycle.
- States: IDLE and CLEAR.
- Transfer: a byte is accepted on any edge where in_valid && in_ready. The resulting write appears on we/w_row/w_col/din for exactly one cycle, starting the cycle after acceptance (latency 1). The cursor update is visible on that same cycle.
- we defaults to 0 every cycle unless a write is issued.
- Printable byte (0x20..0x7E):
  - Write the byte at (cur_row, cur_col), then advance cur_col.
  - At cur_col==COLS-1: cur_col becomes 0 and cur_row increments.
  - At row ROWS-1 the row wraps to 0. There is no scrolling.
- LF (0x0A): no write; cur_col=0, cur_row=(cur_row+1) mod ROWS.
- CR (0x0D): no write; cur_col=0, row unchanged.
- BS (0x08):
  - Move the cursor back one cell, then write 0x20 at the new position.
  - From (r,0) with r>0, the cursor goes to (r-1, COLS-1).
  - At (0,0): no write and no movement, but the byte is still consumed.
- Any other byte (other control codes, >=0x7F): consumed and dropped; no write, no cursor change.
- Clear:
  - clear high in IDLE enters CLEAR on the next edge with busy=1. Clear takes priority over a simultaneous in_valid; in_ready is low that cycle, so the byte is not accepted.
  - CLEAR writes 0x20 to every cell in row-major order, (0,0) first and (ROWS-1,COLS-1) last, one cell per cycle with we=1. That is exactly ROWS*COLS write cycles.
  - After the last write: return to IDLE, busy=0, cursor=(0,0).
  - in_ready is 0 throughout CLEAR. clear asserted during CLEAR is ignored and does not restart the sweep.
- Width rules:
  - Row and column counters have exactly $clog2 width.
  - When ROWS or COLS is not a power of two, wrap compares against ROWS-1/COLS-1 explicitly, never relying on natural overflow.
- Back-to-back: one byte per cycle is sustained in IDLE. Consecutive accepted printable bytes produce writes on consecutive cycles.

Test Plan:
- Reset check: after rst, send "Hi" (0x48, 0x69) on consecutive cycles -> we=1 at (0,0) din=0x48, then (0,1) din=0x69; cursor (0,2). Read back via RAM read port.
- Column and row wrap (ROWS=4, COLS=32): send 32 x 'A' -> the last write is at (0,31) and cursor=(1,0). Then send LF x3 -> cursor=(0,0), with no writes during the LFs.
- Backspace edges:
  - At (1,0), send 0x08 -> write 0x20 at (0,31), cursor=(0,31).
  - At (0,0), send 0x08 -> no we, cursor stays (0,0), in_ready remains 1.
- Control filtering: send 0x07, 0x7F, 0x0D at cursor (2,5) -> no we; cursor=(2,0) after CR only.
- Clear:
  - Pulse clear with in_valid=1 and in_data=0x41 on the same cycle -> byte not accepted. busy=1 for 128 cycles with 128 writes of 0x20 covering (0,0)..(3,31) in order. Then busy=0, cursor=(0,0), in_ready=1.
  - A clear pulse mid-sweep does not extend the sweep.
- Reset mid-clear: assert rst at sweep cycle 40 -> we=0 next cycle, state IDLE, cursor=(0,0). Cells 40..127 keep their prior contents.
